// File: rtl/display_scan_sched.sv
// Refresh scheduler for a 4-digit multiplexed 7-segment display: slot timer, blanked/PWM
// anodes and double-buffered display data that only swaps at frame boundaries.
module display_scan_sched #(
   parameter int unsigned CLK_DIV   = 50000,
   parameter int unsigned BLANK_CYC = 16
) (
   input  logic        i_Clk,
   input  logic        i_Reset,
   input  logic        i_Enable,
   input  logic [15:0] i_Data,
   input  logic        i_Load,
   input  logic [3:0]  i_Bright,
   output logic [1:0]  o_Sel,
   output logic [3:0]  o_Anodos,
   output logic [3:0]  o_Nibble,
   output logic        o_Ack,
   output logic        o_Frame
);

   localparam int unsigned CW = $clog2(CLK_DIV);

   typedef enum logic {IDLE, SCAN} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [15:0]   active;
   logic [15:0]   shadow;
   logic          pending;

   logic          last_cyc;
   logic          boundary;
   logic          apply;
   logic [CW-1:0] cnt_nx;
   logic [1:0]    sel_nx;
   logic [15:0]   active_nx;
   logic [15:0]   shadow_nx;
   logic          pending_nx;
   logic          ack_nx;
   logic          anode_on;
   logic [3:0]    anode_nx;
   logic [3:0]    nib_nx;

   always_comb begin
      last_cyc = (cnt == CW'(CLK_DIV - 1));
      // The idle->scan edge also starts a frame, so it doubles as a load boundary.
      boundary = i_Enable && ((state == IDLE) || (last_cyc && (o_Sel == 2'd3)));
      apply    = boundary || (state == IDLE);

      cnt_nx = '0;
      sel_nx = 2'd0;
      if (i_Enable && (state == SCAN)) begin
         if (last_cyc) begin
            sel_nx = o_Sel + 2'd1;
         end else begin
            cnt_nx = cnt + CW'(1);
            sel_nx = o_Sel;
         end
      end

      active_nx  = active;
      shadow_nx  = shadow;
      pending_nx = pending;
      ack_nx     = 1'b0;
      if (boundary && i_Load) begin
         active_nx  = i_Data;
         pending_nx = 1'b0;
         ack_nx     = 1'b1;
      end else begin
         if (apply && pending) begin
            active_nx  = shadow;
            pending_nx = 1'b0;
            ack_nx     = 1'b1;
         end
         if (i_Load) begin
            shadow_nx  = i_Data;
            pending_nx = 1'b1;
         end
      end

      // Output registers are loaded from next-state, so i_Bright shows up one cycle later.
      anode_on = i_Enable && (cnt_nx >= CW'(BLANK_CYC)) && (cnt_nx[3:0] <= i_Bright);
      anode_nx = anode_on ? (4'b1111 ^ (4'b1000 >> sel_nx)) : 4'b1111;
      nib_nx   = active_nx[{sel_nx, 2'b00} +: 4];
   end

   always_ff @(posedge i_Clk or posedge i_Reset) begin
      if (i_Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         active   <= '0;
         shadow   <= '0;
         pending  <= 1'b0;
         o_Sel    <= 2'd0;
         o_Anodos <= 4'b1111;
         o_Nibble <= 4'd0;
         o_Ack    <= 1'b0;
         o_Frame  <= 1'b0;
      end else begin
         state    <= i_Enable ? SCAN : IDLE;
         cnt      <= cnt_nx;
         active   <= active_nx;
         shadow   <= shadow_nx;
         pending  <= pending_nx;
         o_Sel    <= sel_nx;
         o_Anodos <= anode_nx;
         o_Nibble <= nib_nx;
         o_Ack    <= ack_nx;
         o_Frame  <= boundary;
      end
   end

endmodule

// File: tb/tb_display_scan_sched.sv
// Randomised bench for display_scan_sched against a frame-time reference model,
// with directed scenarios for blanking, PWM, load timing, enable drop and reset.
module tb_display_scan_sched;

   localparam int unsigned DIV   = 32;
   localparam int unsigned BLANK = 4;
   localparam int unsigned FRAME = 4 * DIV;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] data;
   logic        load;
   logic [3:0]  bright;
   logic [1:0]  sel;
   logic [3:0]  anodos;
   logic [3:0]  nibble;
   logic        ack;
   logic        frame;

   int checks = 0;
   int errors = 0;

   // Reference model: t counts cycles since scanning began; slot and digit follow from it.
   int unsigned m_t;
   bit          m_scan;
   logic [15:0] m_active;
   logic [15:0] m_shadow;
   bit          m_pending;
   logic [1:0]  e_sel;
   logic [3:0]  e_an;
   logic [3:0]  e_nib;
   logic        e_ack;
   logic        e_frame;
   logic [3:0]  pat [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

   display_scan_sched #(.CLK_DIV(DIV), .BLANK_CYC(BLANK)) dut (
      .i_Clk    (clk),
      .i_Reset  (rst),
      .i_Enable (en),
      .i_Data   (data),
      .i_Load   (load),
      .i_Bright (bright),
      .o_Sel    (sel),
      .o_Anodos (anodos),
      .o_Nibble (nibble),
      .o_Ack    (ack),
      .o_Frame  (frame)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_t = 0; m_scan = 0; m_active = '0; m_shadow = '0; m_pending = 0;
      e_sel = 2'd0; e_an = 4'hF; e_nib = 4'd0; e_ack = 0; e_frame = 0;
   endtask

   task automatic model_edge();
      bit was_idle;
      bit bnd;
      int unsigned c;
      was_idle = !m_scan;
      if (en) m_t = was_idle ? 0 : m_t + 1;
      bnd = en && ((m_t % FRAME) == 0);
      e_ack = 0;
      if (bnd && load) begin
         m_active = data; m_pending = 0; e_ack = 1;
      end else begin
         if ((bnd || was_idle) && m_pending) begin
            m_active = m_shadow; m_pending = 0; e_ack = 1;
         end
         if (load) begin
            m_shadow = data; m_pending = 1;
         end
      end
      if (en) begin
         c     = m_t % DIV;
         e_sel = 2'((m_t / DIV) % 4);
         e_an  = (c >= BLANK && (c % 16) <= bright) ? pat[e_sel] : 4'hF;
      end else begin
         e_sel = 2'd0;
         e_an  = 4'hF;
      end
      e_frame = bnd;
      e_nib   = 4'((m_active >> (4 * e_sel)) & 16'hF);
      m_scan  = en;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check("sel", 16'(sel), 16'(e_sel));
      check("anodos", 16'(anodos), 16'(e_an));
      check("nibble", 16'(nibble), 16'(e_nib));
      check("ack", 16'(ack), 16'(e_ack));
      check("frame", 16'(frame), 16'(e_frame));
   endtask

   task automatic wait_phase(input int unsigned ph);
      int n = 0;
      while (!(m_scan && (m_t % FRAME) == ph) && n < 4 * FRAME) begin
         tick();
         n++;
      end
      if (n >= 4 * FRAME) check("wait_timeout", 16'd0, 16'd1);
   endtask

   initial begin
      int cnt_on;
      int cnt_ack;
      rst = 1; en = 0; load = 0; data = '0; bright = 4'd15;
      model_reset();
      #2;
      check("rst_sel", 16'(sel), 16'd0);
      check("rst_an", 16'(anodos), 16'hF);
      check("rst_nib", 16'(nibble), 16'd0);
      check("rst_ack", 16'(ack), 16'd0);
      check("rst_frame", 16'(frame), 16'd0);
      @(negedge clk);
      rst = 0;

      // Load while idle: applied one edge later.
      data = 16'h4321; load = 1;
      tick();
      load = 0;
      tick();
      check("idle_ack", 16'(ack), 16'd1);
      en = 1;
      tick();
      check("first_frame", 16'(frame), 16'd1);
      for (int i = 1; i < int'(FRAME); i++) begin
         tick();
         if (i % DIV == 10) begin
            check("first_nib", 16'(nibble), 16'(i / DIV + 1));
            check("first_an", 16'(anodos), 16'(pat[i / DIV]));
         end
         if (i % DIV < 4) check("blank", 16'(anodos), 16'hF);
      end

      // PWM: brightness 0 lights only c=16; brightness 7 lights c=4..7,16..23.
      wait_phase(FRAME - 1);
      bright = 4'd0;
      cnt_on = 0;
      for (int i = 0; i < int'(FRAME); i++) begin
         tick();
         if (anodos != 4'hF) cnt_on++;
      end
      check("bright0_on", 16'(cnt_on), 16'd4);
      bright = 4'd7;
      cnt_on = 0;
      for (int i = 0; i < int'(FRAME); i++) begin
         tick();
         if (anodos != 4'hF) cnt_on++;
      end
      check("bright7_on", 16'(cnt_on), 16'd48);
      bright = 4'd15;

      // Two loads mid-frame: last one wins, single ack at the next frame.
      wait_phase(DIV + 5);
      data = 16'hAAAA; load = 1;
      tick();
      load = 0;
      wait_phase(2 * DIV + 5);
      data = 16'hBBBB; load = 1;
      tick();
      load = 0;
      cnt_ack = 0;
      while ((m_t % FRAME) != FRAME - 1) begin
         tick();
         if (ack) cnt_ack++;
      end
      check("no_early_ack", 16'(cnt_ack), 16'd0);
      check("old_nib", 16'(nibble), 16'd4);
      for (int i = 0; i < int'(FRAME); i++) begin
         tick();
         if (ack) cnt_ack++;
         if (i % DIV == 10) check("new_nib", 16'(nibble), 16'hB);
      end
      check("one_ack", 16'(cnt_ack), 16'd1);

      // Load exactly on the boundary edge: bypass into the active register.
      wait_phase(FRAME - 1);
      data = 16'h1234; load = 1;
      tick();
      load = 0;
      check("bypass_ack", 16'(ack), 16'd1);
      check("bypass_nib0", 16'(nibble), 16'd4);
      cnt_ack = 0;
      for (int i = 1; i < int'(FRAME); i++) begin
         tick();
         if (ack) cnt_ack++;
         if (i % DIV == 10) check("bypass_nib", 16'(nibble), 16'(4 - i / DIV));
      end
      check("bypass_one_ack", 16'(cnt_ack), 16'd0);

      // Enable drop mid-slot, then resume.
      wait_phase(2 * DIV + 10);
      en = 0;
      tick();
      check("drop_an", 16'(anodos), 16'hF);
      check("drop_sel", 16'(sel), 16'd0);
      repeat (5) tick();
      en = 1;
      tick();
      check("resume_frame", 16'(frame), 16'd1);

      // Randomised operation.
      for (int i = 0; i < 3000; i++) begin
         tick();
         if ($urandom_range(0, 299) == 0) en = ~en;
         else if (!en && $urandom_range(0, 9) == 0) en = 1;
         load = ($urandom_range(0, 39) == 0);
         data = 16'($urandom);
         if ($urandom_range(0, 49) == 0) bright = 4'($urandom);
      end
      load = 0;
      en = 1;

      // Asynchronous reset mid-frame with a load pending.
      wait_phase(3 * DIV + 20);
      data = 16'hCAFE; load = 1;
      tick();
      load = 0;
      @(negedge clk);
      rst = 1;
      #1;
      check("arst_an", 16'(anodos), 16'hF);
      check("arst_sel", 16'(sel), 16'd0);
      check("arst_nib", 16'(nibble), 16'd0);
      check("arst_ack", 16'(ack), 16'd0);
      model_reset();
      @(posedge clk);
      #1;
      check("arst_hold_ack", 16'(ack), 16'd0);
      @(negedge clk);
      rst = 0;
      for (int i = 0; i < int'(FRAME) + 4; i++) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
